// File: rtl/z80fi_insn_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : z80fi_insn_capture_if
// Purpose  : Bundles the core-side fetch/retire strobes and the published
//            z80fi record into one connection.
//            master : driven by the core (fetch/retire/live registers),
//                     receives the record.
//            slave  : the capture block (consumes strobes, drives record).
// Params   : MAX_LEN - instruction bytes held per record (1..7).
// Macro    : Z80FI_ORDER_EN adds the 64-bit z80fi_order record field.
// Revision : 1.0 - initial release
// ============================================================================
interface z80fi_insn_capture_if #(
  parameter int MAX_LEN = 4
);
  // core side
  logic                   fetch_valid;
  logic [7:0]             fetch_byte;
  logic [15:0]            fetch_addr;
  logic                   retire;
  logic [7:0]             reg_a;
  logic [7:0]             reg_f;
  logic [15:0]            reg_hl;
  // published record
  logic                   z80fi_valid;
  logic [8*MAX_LEN-1:0]   z80fi_insn;
  logic [2:0]             z80fi_insn_len;
  logic [15:0]            z80fi_reg_ip_in;
  logic [7:0]             z80fi_reg_a_in;
  logic [7:0]             z80fi_reg_f_in;
  logic [15:0]            z80fi_reg_hl_in;
  logic                   z80fi_overflow;
`ifdef Z80FI_ORDER_EN
  logic [63:0]            z80fi_order;
`endif

  modport master (
    output fetch_valid, fetch_byte, fetch_addr, retire, reg_a, reg_f, reg_hl,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
           z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_hl_in, z80fi_overflow
`ifdef Z80FI_ORDER_EN
    , input z80fi_order
`endif
  );

  modport slave (
    input  fetch_valid, fetch_byte, fetch_addr, retire, reg_a, reg_f, reg_hl,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
           z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_hl_in, z80fi_overflow
`ifdef Z80FI_ORDER_EN
    , output z80fi_order
`endif
  );
endinterface
`default_nettype wire

// File: rtl/z80fi_insn_capture.sv
`default_nettype none
// ============================================================================
// Module   : z80fi_insn_capture
// Purpose  : Assembles the bytes fetched for each Z80 instruction into a
//            little-endian word, snapshots A/F/HL and the start address at
//            the first byte, and publishes one registered z80fi record for a
//            single cycle after retire.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-high
//            bus   - z80fi_insn_capture_if.slave (fetch/retire strobes in,
//                    z80fi record out)
// Params   : MAX_LEN - bytes captured per instruction (1..7, len is 3 bits).
// Macro    : Z80FI_ORDER_EN - when defined, maintains a 64-bit retire
//            sequence number presented as z80fi_order.
// Revision : 1.0 - initial release
// ============================================================================
module z80fi_insn_capture #(
  parameter int MAX_LEN = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  z80fi_insn_capture_if.slave bus
);

  localparam int INSN_W = 8 * MAX_LEN;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t state, state_next;

  // collection buffer and start-of-instruction snapshot
  logic [INSN_W-1:0] insn_buf;
  logic [2:0]        count;
  logic [15:0]       snap_ip;
  logic [7:0]        snap_a;
  logic [7:0]        snap_f;
  logic [15:0]       snap_hl;

  // record registers
  logic              rec_valid;
  logic [INSN_W-1:0] rec_insn;
  logic [2:0]        rec_len;
  logic [15:0]       rec_ip;
  logic [7:0]        rec_a;
  logic [7:0]        rec_f;
  logic [15:0]       rec_hl;
  logic              overflow;

  // combinational view of the buffer with this cycle's byte merged in
  logic [INSN_W-1:0] buf_next;
  logic [2:0]        count_next;
  logic [2:0]        lane;
  logic              full;
  logic              accept;
  logic              publish;
  logic [15:0]       start_ip;
  logic [7:0]        start_a;
  logic [7:0]        start_f;
  logic [15:0]       start_hl;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath steering
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    lane       = (state == ST_IDLE) ? 3'd0 : count;
    full       = (state == ST_COLLECT) && (count == 3'(MAX_LEN));
    accept     = bus.fetch_valid && !full;
    // A retire with a byte on the same cycle counts even from IDLE: that
    // byte is the whole (single-byte) instruction.
    publish    = bus.retire && ((state == ST_COLLECT) || bus.fetch_valid);
    count_next = accept ? (count + 3'd1) : count;

    buf_next = insn_buf;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (accept && (lane == 3'(i))) begin
        buf_next[8*i +: 8] = bus.fetch_byte;
      end
    end

    // When the first byte arrives together with retire, the snapshot
    // registers have not been loaded yet, so publish the live values.
    if (state == ST_IDLE) begin
      start_ip = bus.fetch_addr;
      start_a  = bus.reg_a;
      start_f  = bus.reg_f;
      start_hl = bus.reg_hl;
    end else begin
      start_ip = snap_ip;
      start_a  = snap_a;
      start_f  = snap_f;
      start_hl = snap_hl;
    end

    case (state)
      ST_IDLE:    if (bus.fetch_valid) state_next = ST_COLLECT;
      ST_COLLECT: state_next = ST_COLLECT;
      default:    state_next = ST_IDLE;
    endcase
    if (publish) begin
      state_next = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer, snapshot and record registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insn_buf  <= '0;
      count     <= 3'd0;
      snap_ip   <= 16'd0;
      snap_a    <= 8'd0;
      snap_f    <= 8'd0;
      snap_hl   <= 16'd0;
      rec_valid <= 1'b0;
      rec_insn  <= '0;
      rec_len   <= 3'd0;
      rec_ip    <= 16'd0;
      rec_a     <= 8'd0;
      rec_f     <= 8'd0;
      rec_hl    <= 16'd0;
      overflow  <= 1'b0;
    end else begin
      rec_valid <= publish;

      if (bus.fetch_valid && full) begin
        overflow <= 1'b1;
      end

      if ((state == ST_IDLE) && bus.fetch_valid) begin
        snap_ip <= bus.fetch_addr;
        snap_a  <= bus.reg_a;
        snap_f  <= bus.reg_f;
        snap_hl <= bus.reg_hl;
      end

      if (publish) begin
        rec_insn <= buf_next;
        rec_len  <= count_next;
        rec_ip   <= start_ip;
        rec_a    <= start_a;
        rec_f    <= start_f;
        rec_hl   <= start_hl;
        // buffer must be clean so unused lanes of the next record read zero
        insn_buf <= '0;
        count    <= 3'd0;
      end else begin
        insn_buf <= buf_next;
        count    <= count_next;
      end
    end
  end

`ifdef Z80FI_ORDER_EN
  // --------------------------------------------------------------------------
  // Retire sequence number: record k carries k
  // --------------------------------------------------------------------------
  logic [63:0] order_cnt;
  logic [63:0] rec_order;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_cnt <= 64'd0;
      rec_order <= 64'd0;
    end else if (publish) begin
      rec_order <= order_cnt;
      order_cnt <= order_cnt + 64'd1;
    end
  end

  assign bus.z80fi_order = rec_order;
`endif

  assign bus.z80fi_valid     = rec_valid;
  assign bus.z80fi_insn      = rec_insn;
  assign bus.z80fi_insn_len  = rec_len;
  assign bus.z80fi_reg_ip_in = rec_ip;
  assign bus.z80fi_reg_a_in  = rec_a;
  assign bus.z80fi_reg_f_in  = rec_f;
  assign bus.z80fi_reg_hl_in = rec_hl;
  assign bus.z80fi_overflow  = overflow;

endmodule
`default_nettype wire

// File: tb/tb_z80fi_insn_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80fi_insn_capture
// Purpose  : Self-checking bench for z80fi_insn_capture. Directed steps from
//            the instruction scenarios followed by random fetch/retire
//            traffic, all compared against a queue-based instruction model.
// Macro    : Z80FI_ORDER_EN - also checks the retire sequence number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80fi_insn_capture;

  localparam int MAX_LEN = 4;

  logic clk = 1'b0;
  logic reset;

  z80fi_insn_capture_if #(.MAX_LEN(MAX_LEN)) bus ();

  z80fi_insn_capture #(.MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: bytes of the current instruction plus its snapshot
  logic [7:0]  mq[$];
  logic [15:0] m_ip, m_hl;
  logic [7:0]  m_a, m_f;
  logic [63:0] m_order;
  // expected outputs
  logic        e_valid;
  logic [63:0] e_insn;
  logic [63:0] e_len;
  logic [15:0] e_ip, e_hl;
  logic [7:0]  e_a, e_f;
  logic        e_ov;
  logic [63:0] e_order;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".valid"}, 64'(bus.z80fi_valid),     64'(e_valid));
    chk({ctx, ".insn"},  64'(bus.z80fi_insn),      e_insn);
    chk({ctx, ".len"},   64'(bus.z80fi_insn_len),  e_len);
    chk({ctx, ".ip"},    64'(bus.z80fi_reg_ip_in), 64'(e_ip));
    chk({ctx, ".a"},     64'(bus.z80fi_reg_a_in),  64'(e_a));
    chk({ctx, ".f"},     64'(bus.z80fi_reg_f_in),  64'(e_f));
    chk({ctx, ".hl"},    64'(bus.z80fi_reg_hl_in), 64'(e_hl));
    chk({ctx, ".ovf"},   64'(bus.z80fi_overflow),  64'(e_ov));
`ifdef Z80FI_ORDER_EN
    chk({ctx, ".order"}, bus.z80fi_order,          e_order);
`endif
  endtask

  task automatic model_clear();
    mq.delete();
    m_ip = '0; m_hl = '0; m_a = '0; m_f = '0; m_order = '0;
    e_valid = 1'b0; e_insn = '0; e_len = '0; e_ip = '0; e_hl = '0;
    e_a = '0; e_f = '0; e_ov = 1'b0; e_order = '0;
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input logic fv, input logic [7:0] b, input logic [15:0] ad,
                      input logic ret, input logic [7:0] a, input logic [7:0] f,
                      input logic [15:0] hl, input string ctx);
    bus.fetch_valid = fv;
    bus.fetch_byte  = b;
    bus.fetch_addr  = ad;
    bus.retire      = ret;
    bus.reg_a       = a;
    bus.reg_f       = f;
    bus.reg_hl      = hl;

    e_valid = 1'b0;
    if (fv) begin
      if (mq.size() == 0) begin
        m_ip = ad; m_a = a; m_f = f; m_hl = hl;
      end
      if (mq.size() < MAX_LEN) mq.push_back(b);
      else                     e_ov = 1'b1;
    end
    if (ret && mq.size() > 0) begin
      e_valid = 1'b1;
      e_insn  = '0;
      foreach (mq[i]) e_insn = e_insn + (64'(mq[i]) << (8 * i));
      e_len   = 64'(mq.size());
      e_ip = m_ip; e_a = m_a; e_f = m_f; e_hl = m_hl;
      e_order = m_order;
      m_order = m_order + 64'd1;
      mq.delete();
    end

    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 16'h0000, ctx);
  endtask

  // Asynchronous reset asserted between edges, held over one edge.
  task automatic do_reset(input string ctx);
    bus.fetch_valid = 1'b0;
    bus.retire      = 1'b0;
    reset = 1'b1;
    #1;
    model_clear();
    check_all({ctx, ".async"});
    @(posedge clk);
    #1;
    check_all({ctx, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] pc;
    logic        fv, ret;

    bus.fetch_valid = 1'b0; bus.fetch_byte = '0; bus.fetch_addr = '0;
    bus.retire = 1'b0; bus.reg_a = '0; bus.reg_f = '0; bus.reg_hl = '0;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;

    // single-byte instruction, retire on the same cycle as the fetch
    step(1'b1, 8'h3C, 16'h0100, 1'b1, 8'h12, 8'h00, 16'h0000, "single");
    chk("plan.single.insn", 64'(bus.z80fi_insn), 64'h0000003C);
    chk("plan.single.len",  64'(bus.z80fi_insn_len), 64'd1);
    idle("single.drop");

    // two-byte ALU immediate; A changes before the operand fetch
    step(1'b1, 8'hC6, 16'h0200, 1'b0, 8'h10, 8'h01, 16'h4000, "alu.op");
    step(1'b1, 8'h05, 16'h0201, 1'b0, 8'h55, 8'h80, 16'h4001, "alu.imm");
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h55, 8'h80, 16'h4001, "alu.ret");
    chk("plan.alu.insn", 64'(bus.z80fi_insn), 64'h000005C6);
    chk("plan.alu.a_in", 64'(bus.z80fi_reg_a_in), 64'h10);
    chk("plan.alu.f_in", 64'(bus.z80fi_reg_f_in), 64'h01);

    // four-byte prefixed instruction, retire on the last byte
    step(1'b1, 8'hDD, 16'h0300, 1'b0, 8'h01, 8'h02, 16'h1111, "ld4.0");
    step(1'b1, 8'h36, 16'h0301, 1'b0, 8'h01, 8'h02, 16'h1111, "ld4.1");
    step(1'b1, 8'h05, 16'h0302, 1'b0, 8'h01, 8'h02, 16'h1111, "ld4.2");
    step(1'b1, 8'h7F, 16'h0303, 1'b1, 8'h01, 8'h02, 16'h1111, "ld4.3");
    chk("plan.ld4.insn", 64'(bus.z80fi_insn), 64'h7F0536DD);
    chk("plan.ld4.ovf",  64'(bus.z80fi_overflow), 64'd0);

    // five fetches overflow the buffer; the fifth byte is dropped
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(8'hA0 + i), 16'(16'h0400 + i), 1'b0, 8'h21, 8'h22, 16'h2323, "ovf.fetch");
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 8'h00, 16'h0000, "ovf.ret");
    chk("plan.ovf.len",  64'(bus.z80fi_insn_len), 64'd4);
    chk("plan.ovf.insn", 64'(bus.z80fi_insn), 64'hA3A2A1A0);
    step(1'b1, 8'h00, 16'h0410, 1'b1, 8'h00, 8'h00, 16'h0000, "ovf.next");
    chk("plan.ovf.sticky", 64'(bus.z80fi_overflow), 64'd1);

    // back-to-back: retire, then next instruction's first fetch right after
    step(1'b1, 8'h00, 16'h0500, 1'b1, 8'h31, 8'h32, 16'h3333, "b2b.nop");
    step(1'b1, 8'h3E, 16'h0501, 1'b0, 8'h41, 8'h42, 16'h4444, "b2b.op");
    step(1'b1, 8'hAA, 16'h0502, 1'b1, 8'h51, 8'h52, 16'h5555, "b2b.imm");
    idle("b2b.drop");

    // spurious retire while idle
    step(1'b0, 8'h77, 16'h0600, 1'b1, 8'h66, 8'h66, 16'h6666, "spur.0");
    step(1'b0, 8'h77, 16'h0600, 1'b1, 8'h66, 8'h66, 16'h6666, "spur.1");

    // reset mid-instruction discards the partial bytes
    step(1'b1, 8'hCB, 16'h0700, 1'b0, 8'h71, 8'h72, 16'h7777, "rst.op");
    step(1'b1, 8'h11, 16'h0701, 1'b0, 8'h71, 8'h72, 16'h7777, "rst.op2");
    do_reset("rst");
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 8'h00, 16'h0000, "rst.noretire");
    step(1'b1, 8'h76, 16'h0800, 1'b1, 8'h81, 8'h82, 16'h8888, "rst.first");

    // random traffic
    pc = 16'h1000;
    for (int n = 0; n < 400; n++) begin
      fv  = ($urandom_range(0, 9) < 6);
      ret = ($urandom_range(0, 9) < 3);
      step(fv, 8'($urandom), pc, ret, 8'($urandom), 8'($urandom), 16'($urandom), "rand");
      if (fv) pc = pc + 16'd1;
      if ($urandom_range(0, 149) == 0) do_reset("rand.rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80fi_insn_capture.md
# z80fi_insn_capture

Upstream feeder for the Z80 formal-interface (z80fi) instruction spec modules. Watches the core's opcode/operand fetch strobes and retire strobe, assembles the fetched bytes of each instruction into a little-endian instruction word with a byte count, and snapshots the architectural state at instruction start. On retire it presents one registered z80fi record (`z80fi_valid`, `z80fi_insn`, `z80fi_insn_len`, `*_in` registers) for one cycle, which every `z80fi_insn_spec_*` checker consumes.

## Interface
Parameters:
- `MAX_LEN`, 4: maximum instruction bytes captured (Z80 max incl. prefixes and displacement/immediate).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_valid`  in  1  core fetched one instruction byte this cycle (M1 opcode or operand read).
- `fetch_byte`  in  8  byte fetched.
- `fetch_addr`  in  16  address of the fetched byte.
- `retire`  in  1  core completed the current instruction this cycle.
- `reg_a`, `reg_f`  in  8 each  live A and F.
- `reg_hl`  in  16  live HL.
- `z80fi_valid`  out  1  one-cycle pulse: record valid.
- `z80fi_insn`  out  `8*MAX_LEN`  instruction bytes, first fetched in [7:0], unused bytes zero.
- `z80fi_insn_len`  out  3  bytes captured (1..MAX_LEN).
- `z80fi_reg_ip_in`  out  16  address of first byte.
- `z80fi_reg_a_in`, `z80fi_reg_f_in`  out  8 each  A/F at first fetch.
- `z80fi_reg_hl_in`  out  16  HL at first fetch.
- `z80fi_overflow`  out  1  sticky: an instruction exceeded MAX_LEN bytes.

## Operation
- States: IDLE (no bytes held), COLLECT (≥1 byte held).
- IDLE + `fetch_valid`: store byte at lane 0, count=1, latch `fetch_addr`, `reg_a`, `reg_f`, `reg_hl` into start snapshot; go COLLECT.
- COLLECT + `fetch_valid`: store byte at lane `count`, count+1. Fetch when count==MAX_LEN: byte dropped, count saturates, `z80fi_overflow` set (sticky until reset).
- `retire` in COLLECT: publish buffer, count, snapshot to outputs; `z80fi_valid`=1 next cycle; clear buffer to zero, count=0; go IDLE.
- `retire` with `fetch_valid` same cycle: that byte is the instruction's final byte and is included in the record (including IDLE + both: record of length 1).
- `retire` in IDLE without `fetch_valid`: ignored, no record, no error.
- Snapshot taken only at the first byte; later register changes before retire do not affect `*_in`.
- Output registers hold last record between pulses; only `z80fi_valid` drops.
- Unused high lanes of `z80fi_insn` are zero.

## Timing
- Record latency: `z80fi_valid` rises the cycle after `retire` is sampled; high exactly one cycle.
- Back-to-back: `retire` on cycle N and first fetch of next instruction on N+1 is supported; a fetch on N+1 starts a fresh record and does not disturb the published one.
- Reset (any time, incl. mid-instruction): state IDLE, count 0, buffer 0; outputs `z80fi_valid`=0, `z80fi_insn`=0, `z80fi_insn_len`=0, all `*_in`=0, `z80fi_overflow`=0. Partially collected instruction is discarded.

## Configuration
- `Z80FI_ORDER_EN`: when defined, adds output `z80fi_order` (64 bits), the retire sequence number: 0 at reset, record k carries k, increments after each published record. When undefined, the port and counter do not exist; all other behaviour is identical.

## Test plan
- Single-byte: fetch 0x3C @0x0100 with retire same cycle, A=0x12 -> next cycle valid=1, insn=0x0000003C, len=1, ip_in=0x0100, a_in=0x12.
- Two-byte ALU immediate: fetch 0xC6 @0x0200 (A=0x10,F=0x01), A changed to 0x55, fetch 0x05, retire -> insn=0x000005C6, len=2, a_in=0x10, f_in=0x01.
- Four-byte prefixed: fetch DD 36 05 7F, retire on last -> insn=0x7F0536DD, len=4, overflow=0.
- Overflow: five fetches then retire -> len=4, byte 5 absent, overflow=1 and stays 1 over next good instruction.
- Back-to-back + reset: retire then fetch next cycle -> prior record intact, new record correct; assert reset after 2 fetches -> all outputs 0, no valid pulse; with `Z80FI_ORDER_EN` order restarts at 0.
- Spurious retire in IDLE -> no valid pulse, outputs unchanged.
